phase_sequencer: RTL

//  Initiator side of the countdown-timer handshake: the traffic-light phase FSM.
//  Per phase: drive a 4-bit duration, pulse start_timer, wait for expired, advance.

---
 rtl/phase_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// This is the traffic-light phase FSM on the initiator side of the
// countdown-timer handshake. For each phase it:
//   1. drives a 4-bit duration on o_value,
//   2. pulses o_start_timer for one cycle,
//   3. waits for i_expired,
//   4. advances to the next phase.
//
// Phase order:
//   MAIN_G -> MAIN_Y -> RED1 -> SIDE_G -> SIDE_Y -> RED2 -> (WALK) -> MAIN_G
//   MAIN_G re-arms itself until a side-road vehicle has been latched.
//
// Optional feature: define PED_WALK_EN to latch i_ped_req and make the WALK
// phase reachable. When it is undefined:
//   - i_ped_req is ignored,
//   - WALK is never entered,
//   - o_walk stays 0.
// The port list is the same in both builds.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_reset_sync   synchronous active-high reset
//   i_expired      timer expiry level (may stay high for several cycles)
//   i_car_sense    side-road vehicle detector level
//   i_ped_req      pedestrian push-button level
//   o_value        duration of the current phase in timer ticks (never 0)
//   o_start_timer  one-cycle pulse that arms the timer
//   o_main_light   main-road lamps {red,yellow,green}, one-hot
//   o_side_light   side-road lamps {red,yellow,green}, one-hot
//   o_walk         pedestrian walk lamp
//   o_phase        current state encoding (debug / verification)
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int T_MAIN_GREEN = 9,
    parameter int T_SIDE_GREEN = 6,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_WALK       = 5,
    parameter int BLANK        = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_sync,
    input  logic       i_expired,
    input  logic       i_car_sense,
    input  logic       i_ped_req,
    output logic [3:0] o_value,
    output logic       o_start_timer,
    output logic [2:0] o_main_light,
    output logic [2:0] o_side_light,
    output logic       o_walk,
    output logic [2:0] o_phase
);

`ifdef PED_WALK_EN
    localparam bit C_PED_EN = 1'b1;
`else
    localparam bit C_PED_EN = 1'b0;
`endif

    // The timer treats a load of 0 as 16 ticks (it wraps), so a duration of 0
    // is promoted to 1. Values above 15 saturate to fit the 4-bit bus.
    function automatic logic [3:0] clamp_dur(input int t);
        if (t < 1) begin
            return 4'd1;
        end else if (t > 15) begin
            return 4'd15;
        end else begin
            return 4'(t);
        end
    endfunction

    localparam logic [3:0] D_MAIN_G  = clamp_dur(T_MAIN_GREEN);
    localparam logic [3:0] D_SIDE_G  = clamp_dur(T_SIDE_GREEN);
    localparam logic [3:0] D_YELLOW  = clamp_dur(T_YELLOW);
    localparam logic [3:0] D_ALL_RED = clamp_dur(T_ALL_RED);
    localparam logic [3:0] D_WALK    = clamp_dur(T_WALK);

    localparam int              C_BLANK = (BLANK < 0) ? 0 : BLANK;
    localparam int              BW      = (C_BLANK < 2) ? 1 : $clog2(C_BLANK + 1);
    localparam logic [BW-1:0]   C_BLANK_LOAD = BW'(C_BLANK);

    typedef enum logic [2:0] {
        S_MAIN_G = 3'd0,
        S_MAIN_Y = 3'd1,
        S_RED1   = 3'd2,
        S_SIDE_G = 3'd3,
        S_SIDE_Y = 3'd4,
        S_RED2   = 3'd5,
        S_WALK   = 3'd6
    } state_t;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    function automatic logic [3:0] dur_of(input state_t s);
        case (s)
            S_MAIN_G: return D_MAIN_G;
            S_MAIN_Y: return D_YELLOW;
            S_SIDE_G: return D_SIDE_G;
            S_SIDE_Y: return D_YELLOW;
            S_WALK:   return D_WALK;
            default:  return D_ALL_RED;
        endcase
    endfunction

    function automatic logic [2:0] main_of(input state_t s);
        case (s)
            S_MAIN_G: return L_GREEN;
            S_MAIN_Y: return L_YELLOW;
            default:  return L_RED;
        endcase
    endfunction

    function automatic logic [2:0] side_of(input state_t s);
        case (s)
            S_SIDE_G: return L_GREEN;
            S_SIDE_Y: return L_YELLOW;
            default:  return L_RED;
        endcase
    endfunction

    state_t          r_phase;
    logic [3:0]      r_value;
    logic            r_start_timer;
    logic [2:0]      r_main_light;
    logic [2:0]      r_side_light;
    logic            r_walk;
    logic            r_side_pend;
    logic            r_ped_pend;
    logic            r_need_start;
    logic [BW-1:0]   r_blank;

    state_t          w_next;
    logic            w_illegal;
    logic            w_blanked;
    logic            w_exit;

    always_comb begin
        w_next    = S_RED2;
        w_illegal = 1'b0;
        case (r_phase)
            S_MAIN_G: w_next = r_side_pend ? S_MAIN_Y : S_MAIN_G;
            S_MAIN_Y: w_next = S_RED1;
            S_RED1:   w_next = S_SIDE_G;
            S_SIDE_G: w_next = S_SIDE_Y;
            S_SIDE_Y: w_next = S_RED2;
            S_RED2:   w_next = (C_PED_EN && r_ped_pend) ? S_WALK : S_MAIN_G;
            S_WALK:   w_next = S_MAIN_G;
            default: begin
                // An unknown code leaves at once, into an all-red phase.
                w_next    = S_RED2;
                w_illegal = 1'b1;
            end
        endcase
        // The start-pulse cycle is blanked on its own. The counter is loaded on
        // the edge that ends the pulse, so expired is ignored for the pulse
        // cycle plus BLANK more. This hides a stale expired that the timer
        // holds until it has actually reloaded.
        w_blanked = r_start_timer || (r_blank != '0);
        w_exit    = w_illegal || (i_expired && !w_blanked);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            r_phase       <= S_MAIN_G;
            r_value       <= D_MAIN_G;
            r_start_timer <= 1'b0;
            r_main_light  <= L_GREEN;
            r_side_light  <= L_RED;
            r_walk        <= 1'b0;
            r_side_pend   <= 1'b0;
            r_ped_pend    <= 1'b0;
            r_need_start  <= 1'b1;
            r_blank       <= '0;
        end else begin
            r_start_timer <= 1'b0;

            if (i_car_sense) begin
                r_side_pend <= 1'b1;
            end
            if (C_PED_EN && i_ped_req) begin
                r_ped_pend <= 1'b1;
            end

            if (r_start_timer) begin
                r_blank <= C_BLANK_LOAD;
            end else if (r_blank != '0) begin
                r_blank <= r_blank - BW'(1);
            end

            if (r_need_start) begin
                // First cycle after reset: arm MAIN_G. Do not look at expired yet.
                r_need_start  <= 1'b0;
                r_start_timer <= 1'b1;
            end else if (w_exit) begin
                r_phase       <= w_next;
                r_value       <= dur_of(w_next);
                r_main_light  <= main_of(w_next);
                r_side_light  <= side_of(w_next);
                r_walk        <= C_PED_EN && (w_next == S_WALK);
                r_start_timer <= 1'b1;
                // These clears come after the sets above, so a request arriving
                // on the entry edge is consumed by the phase being entered.
                if (w_next == S_SIDE_G) begin
                    r_side_pend <= 1'b0;
                end
                if (w_next == S_WALK) begin
                    r_ped_pend <= 1'b0;
                end
            end
        end
    end

    assign o_value       = r_value;
    assign o_start_timer = r_start_timer;
    assign o_main_light  = r_main_light;
    assign o_side_light  = r_side_light;
    assign o_walk        = r_walk;
    assign o_phase       = r_phase;

endmodule
